// File: rtl/key_schedule_store.sv
// AES-128 key-schedule controller for the decryption datapath.
// Walks the cipher key through ten rounds of getNextRoundKey, keeps round keys
// 0..10 in a flop-based register file and serves them through a registered read
// port. The inverse cipher reads them back starting with round 10.
//
// Handshake: start is a one-cycle pulse. It is accepted only in IDLE or DONE,
// and ignored while busy. keys_valid stays high until the next accepted start.
// rd_en/rd_round are sampled on every rising edge. rd_key updates one cycle
// later and holds its value while rd_en is low.

// S-box stage: SubWord on a 32-bit word, followed by LAT register stages.
// The S-box value is computed arithmetically: the inverse in GF(2^8) followed
// by the affine transform.
module sub_box #(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse. It maps 0 to 0, as the S-box needs.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [31:0] sub_comb;

  // Byte-wise substitution of the incoming word
  always_comb begin
    sub_comb = {sbox(word_i[31:24]), sbox(word_i[23:16]),
                sbox(word_i[15:8]),  sbox(word_i[7:0])};
  end

  if (LAT == 0) begin : g_comb
    assign word_o = sub_comb;
  end else begin : g_pipe
    logic [31:0] pipe_q [LAT];

    // Delay line that models the clocked S-box latency
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= sub_comb;
        for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign word_o = pipe_q[LAT-1];
  end

endmodule

// Single-round AES-128 key expansion. nextKey is consistent SBOX_LAT cycles
// after prevKey settles, because the SubWord path is registered.
module getNextRoundKey #(
  parameter int SBOX_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] prevKey,
  input  logic [31:0]  roundConstant,
  output logic [127:0] nextKey
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w3;
  logic [31:0] sub_w3;
  logic [31:0] temp;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = prevKey;
  assign rot_w3 = {w3[23:0], w3[31:24]};

  sub_box #(.LAT(SBOX_LAT)) u_sub_box (
    .clk    (clk),
    .rst_n  (rst_n),
    .word_i (rot_w3),
    .word_o (sub_w3)
  );

  // XOR chain that produces the four words of the next round key
  always_comb begin
    temp    = sub_w3 ^ roundConstant;
    n0      = w0 ^ temp;
    n1      = w1 ^ n0;
    n2      = w2 ^ n1;
    n3      = w3 ^ n2;
    nextKey = {n0, n1, n2, n3};
  end

endmodule

// Top: sequencing FSM, round-key register file and registered read port.
module key_schedule_store #(
  parameter int SBOX_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] cipher_key,
  output logic         busy,
  output logic         keys_valid,
  input  logic         rd_en,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [1:0] LAT_W = 2'(SBOX_LAT);

  state_e       state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [1:0]   wait_q, wait_d;
  logic [127:0] prev_key_q, prev_key_d;
  logic [127:0] key_mem_q [11];
  logic [127:0] rd_key_q;

  logic         mem_we;
  logic [3:0]   mem_idx;
  logic [127:0] mem_wdata;
  logic [7:0]   rcon_b;
  logic [127:0] next_key;

  // Round constant for the round currently being expanded
  always_comb begin
    rcon_b = 8'h00;
    case (round_q)
      4'd1:    rcon_b = 8'h01;
      4'd2:    rcon_b = 8'h02;
      4'd3:    rcon_b = 8'h04;
      4'd4:    rcon_b = 8'h08;
      4'd5:    rcon_b = 8'h10;
      4'd6:    rcon_b = 8'h20;
      4'd7:    rcon_b = 8'h40;
      4'd8:    rcon_b = 8'h80;
      4'd9:    rcon_b = 8'h1b;
      4'd10:   rcon_b = 8'h36;
      default: rcon_b = 8'h00;
    endcase
  end

  getNextRoundKey #(.SBOX_LAT(SBOX_LAT)) u_next_key (
    .clk           (clk),
    .rst_n         (rst_n),
    .prevKey       (prev_key_q),
    .roundConstant ({rcon_b, 24'h0}),
    .nextKey       (next_key)
  );

  // Next state and register-file write control. prev_key_q is held for
  // SBOX_LAT+1 cycles per round so the S-box path has settled before capture.
  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    wait_d     = wait_q;
    prev_key_d = prev_key_q;
    mem_we     = 1'b0;
    mem_idx    = round_q;
    mem_wdata  = next_key;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = EXPAND;
          prev_key_d = cipher_key;
          round_d    = 4'd1;
          wait_d     = 2'd0;
          mem_we     = 1'b1;
          mem_idx    = 4'd0;
          mem_wdata  = cipher_key;
        end
      end
      EXPAND: begin
        if (wait_q != LAT_W) begin
          wait_d = wait_q + 2'd1;
        end else begin
          mem_we     = 1'b1;
          mem_idx    = round_q;
          mem_wdata  = next_key;
          prev_key_d = next_key;
          wait_d     = 2'd0;
          if (round_q == 4'd10) state_d = DONE;
          else                  round_d = round_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, counters and the chaining key register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      round_q    <= 4'd1;
      wait_q     <= 2'd0;
      prev_key_q <= '0;
    end else begin
      state_q    <= state_d;
      round_q    <= round_d;
      wait_q     <= wait_d;
      prev_key_q <= prev_key_d;
    end
  end

  // Round-key register file, one write per edge at most
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 11; i++) key_mem_q[i] <= '0;
    end else if (mem_we) begin
      key_mem_q[mem_idx] <= mem_wdata;
    end
  end

  // Registered read port. An out-of-range index returns zero. A same-edge
  // write is not forwarded, so the read returns the old content.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_key_q <= '0;
    end else if (rd_en) begin
      if (rd_round <= 4'd10) rd_key_q <= key_mem_q[rd_round];
      else                   rd_key_q <= '0;
    end
  end

  assign busy       = (state_q == EXPAND);
  assign keys_valid = (state_q == DONE);
  assign rd_key     = rd_key_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_key_schedule_store.sv
// Bench for key_schedule_store. Builds with SBOX_LAT = 0, 1 and 2 share one
// stimulus stream. A reference key expansion, built on a table S-box, predicts
// busy, keys_valid and rd_key on every cycle. Directed FIPS-197 literals pin
// both the reference and the DUTs.
module tb_key_schedule_store;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] cipher_key = '0;
  logic         rd_en = 1'b0;
  logic [3:0]   rd_round = '0;

  logic [2:0]   busy_v;
  logic [2:0]   valid_v;
  logic [383:0] rdk_v;
  logic [5:0]   state_v;

  int n_vec  = 0;
  int n_fail = 0;
  bit cmp_on = 1'b0;

  localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    key_schedule_store #(.SBOX_LAT(g)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .cipher_key (cipher_key),
      .busy       (busy_v[g]),
      .keys_valid (valid_v[g]),
      .rd_en      (rd_en),
      .rd_round   (rd_round),
      .rd_key     (rdk_v[g*128 +: 128]),
      .dbg_state  (state_v[g*2 +: 2])
    );
  end

  // ---------------- reference model ----------------
  logic [7:0]   sbox_t [256];
  logic [127:0] sbox_rows [16];
  logic [127:0] fips_rk [11];

  logic [127:0] m_sched [3][11];
  logic [127:0] m_mem   [3][11];
  logic [127:0] m_rd    [3];
  logic         m_active [3];
  logic         m_done   [3];
  int           m_e0     [3];
  int           cyc = 0;

  function automatic logic [127:0] ref_round_key(input logic [127:0] key, input int r);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0]  rc;
    rc = 8'h01;
    {w0, w1, w2, w3} = key;
    for (int i = 1; i <= r; i++) begin
      t  = {sbox_t[w3[23:16]], sbox_t[w3[15:8]], sbox_t[w3[7:0]], sbox_t[w3[31:24]]} ^ {rc, 24'h0};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
    end
    return {w0, w1, w2, w3};
  endfunction

  task automatic model_reset();
    for (int l = 0; l < 3; l++) begin
      m_rd[l]     = '0;
      m_active[l] = 1'b0;
      m_done[l]   = 1'b0;
      m_e0[l]     = 0;
      for (int k = 0; k < 11; k++) begin
        m_mem[l][k]   = '0;
        m_sched[l][k] = '0;
      end
    end
    cyc = 0;
  endtask

  // Round k lands k*(lat+1) edges after the accepting edge. The whole
  // schedule is computed up front when start is accepted.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        for (int l = 0; l < 3; l++) begin
          if (rd_en) begin
            if (rd_round <= 4'd10) m_rd[l] = m_mem[l][rd_round];
            else                   m_rd[l] = '0;
          end
          if (m_active[l]) begin
            int n;
            n = cyc - m_e0[l];
            if (n % (l + 1) == 0) begin
              m_mem[l][n / (l + 1)] = m_sched[l][n / (l + 1)];
              if (n / (l + 1) == 10) begin
                m_active[l] = 1'b0;
                m_done[l]   = 1'b1;
              end
            end
          end else if (start) begin
            m_active[l] = 1'b1;
            m_done[l]   = 1'b0;
            m_e0[l]     = cyc;
            for (int k = 0; k < 11; k++) m_sched[l][k] = ref_round_key(cipher_key, k);
            m_mem[l][0] = cipher_key;
          end
        end
        cyc++;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        for (int l = 0; l < 3; l++) begin
          check($sformatf("busy_L%0d", l),  {127'd0, busy_v[l]},  {127'd0, m_active[l]});
          check($sformatf("valid_L%0d", l), {127'd0, valid_v[l]}, {127'd0, m_done[l]});
          check($sformatf("rd_key_L%0d", l), rdk_v[l*128 +: 128], m_rd[l]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_all_rd(input string name, input logic [127:0] exp);
    for (int l = 0; l < 3; l++) check($sformatf("%s_L%0d", name, l), rdk_v[l*128 +: 128], exp);
  endtask

  task automatic check_idle_outputs(input string name);
    for (int l = 0; l < 3; l++) begin
      check($sformatf("%s_busy_L%0d", name, l),  {127'd0, busy_v[l]},  128'd0);
      check($sformatf("%s_valid_L%0d", name, l), {127'd0, valid_v[l]}, 128'd0);
      check($sformatf("%s_rdkey_L%0d", name, l), rdk_v[l*128 +: 128], 128'd0);
    end
  endtask

  // Pulse start and measure when keys_valid rises, in edges after E0.
  // Optionally fires a second start while the expansion is in progress.
  task automatic run_expand(input logic [127:0] key, input bit inject, input bit restart);
    int rise [3];
    for (int l = 0; l < 3; l++) rise[l] = -1;
    @(posedge clk);
    #1;
    if (restart) check("pre_restart_valid", {125'd0, valid_v}, {125'd0, 3'b111});
    #1;
    start      = 1'b1;
    cipher_key = key;
    @(posedge clk);
    #1;
    if (restart) check("valid_drop_on_e0", {125'd0, valid_v}, 128'd0);
    check("busy_after_e0", {125'd0, busy_v}, {125'd0, 3'b111});
    #1;
    start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      for (int l = 0; l < 3; l++) if (valid_v[l] && rise[l] < 0) rise[l] = n;
      if (inject && n == 5) begin
        start      = 1'b1;
        cipher_key = '0;
      end else if (inject && n == 6) begin
        start = 1'b0;
      end
    end
    for (int l = 0; l < 3; l++)
      check($sformatf("valid_rise_L%0d", l), 128'(rise[l]), 128'(10 * (l + 1)));
  endtask

  task automatic read_check(input logic [3:0] r, input logic [127:0] exp, input string name);
    @(posedge clk);
    #2;
    rd_en    = 1'b1;
    rd_round = r;
    @(posedge clk);
    #1;
    check_all_rd(name, exp);
    #1;
    rd_en = 1'b0;
  endtask

  // Rounds 10 down to 0 on back-to-back cycles, then one out-of-range read
  task automatic reverse_readout();
    @(posedge clk);
    #2;
    rd_en    = 1'b1;
    rd_round = 4'd10;
    for (int i = 10; i >= 0; i--) begin
      @(posedge clk);
      #1;
      check_all_rd($sformatf("rev_r%0d", i), fips_rk[i]);
      #1;
      if (i > 0) rd_round = 4'(i - 1);
      else       rd_round = 4'd15;
    end
    @(posedge clk);
    #1;
    check_all_rd("rd_oob15", 128'd0);
    #1;
    rd_en = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    sbox_rows[0]  = 128'h637c777bf26b6fc53001672bfed7ab76;
    sbox_rows[1]  = 128'hca82c97dfa5947f0add4a2af9ca472c0;
    sbox_rows[2]  = 128'hb7fd9326363ff7cc34a5e5f171d83115;
    sbox_rows[3]  = 128'h04c723c31896059a071280e2eb27b275;
    sbox_rows[4]  = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
    sbox_rows[5]  = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
    sbox_rows[6]  = 128'hd0efaafb434d338545f9027f503c9fa8;
    sbox_rows[7]  = 128'h51a3408f929d38f5bcb6da2110fff3d2;
    sbox_rows[8]  = 128'hcd0c13ec5f974417c4a77e3d645d1973;
    sbox_rows[9]  = 128'h60814fdc222a908846eeb814de5e0bdb;
    sbox_rows[10] = 128'he0323a0a4906245cc2d3ac629195e479;
    sbox_rows[11] = 128'he7c8376d8dd54ea96c56f4ea657aae08;
    sbox_rows[12] = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
    sbox_rows[13] = 128'h703eb5664803f60e613557b986c11d9e;
    sbox_rows[14] = 128'he1f8981169d98e949b1e87e9ce5528df;
    sbox_rows[15] = 128'h8ca1890dbfe6426841992d0fb054bb16;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        sbox_t[r*16 + c] = sbox_rows[r][127 - 8*c -: 8];

    fips_rk[0]  = KEY_FIPS;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    // Pin the reference expansion to known answers
    check("model_fips_r1",  ref_round_key(KEY_FIPS, 1),  fips_rk[1]);
    check("model_fips_r10", ref_round_key(KEY_FIPS, 10), fips_rk[10]);
    check("model_seq_r10",  ref_round_key(KEY_SEQ, 10),  128'h13111d7fe3944a17f307a78b4d2b30c5);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    #2;
    rst_n  = 1'b1;
    cmp_on = 1'b1;
    repeat (2) @(posedge clk);

    // FIPS-197 expansion with a stray start at E0+6 that must be ignored
    run_expand(KEY_FIPS, 1'b1, 1'b0);
    read_check(4'd1,  fips_rk[1],  "t1_r1");
    read_check(4'd10, fips_rk[10], "t1_r10");
    read_check(4'd0,  KEY_FIPS,    "t1_r0");
    reverse_readout();

    // Restart from DONE with a different key
    run_expand(KEY_SEQ, 1'b0, 1'b1);
    read_check(4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "t4_r10");
    read_check(4'd0,  KEY_SEQ, "t4_r0");

    // Asynchronous reset seven edges into an expansion
    @(posedge clk);
    #2;
    start      = 1'b1;
    cipher_key = KEY_FIPS;
    @(posedge clk);
    #2;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int r = 0; r <= 10; r++) read_check(4'(r), 128'd0, $sformatf("post_reset_r%0d", r));

    // A clean expansion after the reset
    run_expand(KEY_FIPS, 1'b0, 1'b0);
    reverse_readout();

    repeat (2) @(posedge clk);
    cmp_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Watchdog: the sequence needs only a few hundred cycles
  initial begin
    #1000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
